// File: rtl/gcd_arb_pkg.sv
// Shared types and default sizing for the GCD-core round-robin scheduler.
package gcd_arb_pkg;

   localparam int DEF_N_REQ   = 4;
   localparam int DEF_WIDTH   = 4;
   localparam int DEF_TIMEOUT = 64;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      SETTLE,
      WAIT,
      RESP
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts just after the last granted index.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any_req
);

   logic [IW-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_req   = 1'b0;
      cand      = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(last_grant) + k) % N);
         if (!any_req && req[cand]) begin
            any_req     = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one GCD core among N_REQ requesters: round-robin accept, start/done sequencing,
// timeout abort and per-requester response return.
module gcd_arbiter
   import gcd_arb_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_x,
   input  logic [N_REQ*WIDTH-1:0] req_y,
   output logic [N_REQ-1:0]       req_ready,
   output logic [N_REQ-1:0]       rsp_valid,
   input  logic [N_REQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   rsp_err,
   output logic [WIDTH-1:0]       gcd_x,
   output logic [WIDTH-1:0]       gcd_y,
   output logic                   gcd_start,
   input  logic                   gcd_done,
   input  logic [WIDTH-1:0]       gcd_out
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT) + 1;

   arb_state_e       state_q, state_d;
   logic [IW-1:0]    last_grant_q, last_grant_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             err_q, err_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [N_REQ-1:0] grant;
   logic [IW-1:0]    grant_idx;
   logic             any_req;
   logic [WIDTH-1:0] sel_x, sel_y;
   logic             rsp_ack;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any_req    (any_req)
   );

   always_comb begin
      sel_x = '0;
      sel_y = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_x = req_x[i*WIDTH +: WIDTH];
            sel_y = req_y[i*WIDTH +: WIDTH];
         end
      end
   end

   assign rsp_ack = rsp_ready[idx_q];

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      idx_d        = idx_q;
      x_d          = x_q;
      y_d          = y_q;
      data_d       = data_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      req_ready    = '0;
      rsp_valid    = '0;
      gcd_start    = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               req_ready = grant;
               idx_d     = grant_idx;
               x_d       = sel_x;
               y_d       = sel_y;
               // A zero operand makes the answer trivial, so the core is skipped.
               if (sel_x == '0 || sel_y == '0) begin
                  data_d  = sel_x | sel_y;
                  err_d   = 1'b0;
                  state_d = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            gcd_start = 1'b1;
            state_d   = SETTLE;
         end
         SETTLE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (gcd_done) begin
               data_d  = gcd_out;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            rsp_valid[idx_q] = 1'b1;
            if (rsp_ack) begin
               last_grant_d = idx_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= IDLE;
         last_grant_q <= IW'(N_REQ - 1);
         idx_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         data_q       <= '0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         idx_q        <= idx_d;
         x_q          <= x_d;
         y_q          <= y_d;
         data_q       <= data_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

   assign gcd_x    = x_q;
   assign gcd_y    = y_q;
   assign rsp_data = data_q;
   assign rsp_err  = err_q;

endmodule
